clint_mmio_master: RTL and testbench
====================================

# clint_mmio_master

MEM-stage initiator for the core-local interruptor register port. Accepts load/store requests from the pipeline, decodes them against the two CLINT registers (mtime at 0x200_BFF8, mtimecmp at 0x200_4000), and drives the CLINT's 64-bit read/write strobes. Sub-doubleword stores are performed as read-modify-write, because the CLINT only accepts full 64-bit writes. Load data is lane-extracted and sign/zero-extended before being returned to the pipeline.

## Interface
Parameters:
- ADDR_MTIME, 64'h200_BFF8, mtime register address (8-byte aligned)
- ADDR_MTIMECMP, 64'h200_4000, mtimecmp register address (8-byte aligned)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted on a cycle where valid && ready
- i_req_wen  in  1  1 = store, 0 = load
- i_req_addr  in  64  byte address
- i_req_wdata  in  64  store data, right-aligned
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- i_req_unsigned  in  1  zero-extend the load (ignored for double)
- o_resp_valid  out  1  one-cycle completion pulse; no backpressure
- o_resp_rdata  out  64  extended load data; 0 for stores and errors
- o_resp_err  out  1  access fault, qualified by o_resp_valid
- o_Clint_addr  out  64  8-byte-aligned register address
- o_Clint_wdata  out  64  full 64-bit write value
- o_Clint_wen  out  1  write strobe
- o_Clint_ren  out  1  read strobe
- i_Clint_rdata  in  64  combinational read data, valid while ren is high

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE:
  - o_req_ready = 1.
  - On accept, latch addr, wdata, size, wen, unsigned, and off = addr[2:0].
- Decode at accept:
  - err if addr[63:3] matches neither register, or if the address is misaligned (off not a multiple of 2^size).
  - err → RESP with err = 1.
  - Load → RD.
  - Double store → WR.
  - Sub-double store → RD.
- RD:
  - ren = 1, addr = latched addr with [2:0] = 0.
  - Capture i_Clint_rdata into rbuf at the clock edge.
  - Load → RESP; store → WR.
- WR:
  - wen = 1 for exactly one cycle, aligned addr.
  - wdata = (rbuf & ~mask) | ((wdata << 8·off) & mask).
  - mask = size-ones (8/16/32/64 bits) << 8·off.
  - Double store ignores rbuf.
  - Next state is RESP.
- RESP:
  - resp_valid = 1.
  - Load rdata = (rbuf >> 8·off) truncated to size, then sign-extended unless unsigned; double returns rbuf.
  - Next state is IDLE.
- Outside RD and WR: o_Clint_addr, o_Clint_wdata = 0; ren, wen = 0.
- ren and wen are never high in the same cycle.

## Timing
- Reset (rst_n low at a clock edge):
  - state → IDLE; rbuf → 0.
  - All outputs are 0 while rst_n is low, including o_req_ready.
- Latency, counted from the accept edge E0:
  - err: resp_valid in the cycle after E0.
  - double store: WR in cycle 1, resp in cycle 2.
  - load: RD in cycle 1, resp in cycle 2.
  - sub-double store: RD, WR, resp in cycles 1, 2, 3.
- Throughput: o_req_ready = 0 in RD, WR and RESP, so the next accept is possible in the cycle after RESP.
- mtime read value is the mtime register in the RD cycle. RMW of mtime writes back rbuf-based data, so any increments between RD and WR are lost by design.
- Reset mid-operation: the request is dropped, no wen is issued, and no response is produced.

## Configuration
- CLINT_MMIO_SUBWORD_EN defined: byte, half and word loads and stores are supported as described.
- CLINT_MMIO_SUBWORD_EN undefined:
  - only size = 3 is legal; any other size → err response in the cycle after accept, with no ren or wen.
  - mask, merge and extension logic is removed; RMW never occurs.

## Test plan
- After reset, ld from 0x200_BFF8: ren high exactly in the cycle after accept; resp 2 cycles after accept; rdata = mtime sampled in the RD cycle; err = 0.
- sd 0x1122334455667788 to 0x200_4000: single wen cycle with that wdata and addr 0x200_4000; a following ld returns 0x1122334455667788.
- With mtimecmp = 0x1122334455667788, sb 0xAB to 0x200_4003: one RD cycle, then one WR with wdata 0x11223344AB667788; resp in cycle 3.
- With mtimecmp = 0xFFFFFFFF00000000:
  - lw from 0x200_4004 → 0xFFFFFFFFFFFFFFFF.
  - lwu → 0x00000000FFFFFFFF.
  - lh from 0x200_4000 → 0.
- Errors:
  - lh at 0x200_4001 → err = 1, rdata = 0, resp in the cycle after accept, no strobes.
  - sd to 0x200_0000 → same error response.
- rst_n low during RD of an sb → no wen is ever asserted, no resp_valid, and o_req_ready = 1 in the first cycle after release. Without CLINT_MMIO_SUBWORD_EN, sw to 0x200_4000 → err with no strobes.

Source files
------------

// File: rtl/clint_mmio_master.sv
// clint_mmio_master: MEM-stage initiator for the core-local interruptor.
// Decodes pipeline loads/stores against mtime/mtimecmp and drives the CLINT's
// 64-bit strobes. Sub-doubleword stores are done as read-modify-write.
// Optional feature macro: CLINT_MMIO_SUBWORD_EN enables byte/half/word access;
// without it only doubleword accesses are legal.
module clint_mmio_master #(
  parameter logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8,
  parameter logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [63:0] o_Clint_addr,
  output logic [63:0] o_Clint_wdata,
  output logic        o_Clint_wen,
  output logic        o_Clint_ren,
  input  logic [63:0] i_Clint_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic        req_wen_q, req_wen_d;
  logic        err_q, err_d;

  logic        ready_q, ready_d;
  logic        cren_q, cren_d;
  logic        cwen_q, cwen_d;
  logic [63:0] caddr_q, caddr_d;
  logic [63:0] cwdata_q, cwdata_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic        hit_s;
  logic        misalign_s;
  logic        size_bad_s;
  logic [2:0]  align_s;

`ifdef CLINT_MMIO_SUBWORD_EN
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  // Byte-lane mask of an access of the given size at the given byte offset.
  function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [63:0] ones;
    case (size)
      2'd0:    ones = 64'h0000_0000_0000_00FF;
      2'd1:    ones = 64'h0000_0000_0000_FFFF;
      2'd2:    ones = 64'h0000_0000_FFFF_FFFF;
      default: ones = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return ones << {off, 3'b000};
  endfunction

  // Merge right-aligned store data into the old register value.
  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [1:0] size, input logic [2:0] off);
    logic [63:0] mask;
    mask = lane_mask(size, off);
    return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  // Extract the addressed lane and sign/zero-extend it.
  function automatic logic [63:0] load_extend(input logic [63:0] rb, input logic [1:0] size,
                                              input logic [2:0] off, input logic uns);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rb >> {off, 3'b000};
    case (size)
      2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = rb;
    endcase
    return res;
  endfunction
`else
  logic unused_s;
  assign unused_s = ^{i_req_unsigned, addr_q[2:0]};
`endif

  // Next-state, request latching and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    req_wen_d = req_wen_q;
    err_d     = err_q;
`ifdef CLINT_MMIO_SUBWORD_EN
    size_d    = size_q;
    uns_d     = uns_q;
`endif

    hit_s = (i_req_addr[63:3] == ADDR_MTIME[63:3]) ||
            (i_req_addr[63:3] == ADDR_MTIMECMP[63:3]);
    case (i_req_size)
      2'd0:    align_s = 3'b000;
      2'd1:    align_s = 3'b001;
      2'd2:    align_s = 3'b011;
      default: align_s = 3'b111;
    endcase
    misalign_s = (i_req_addr[2:0] & align_s) != 3'b000;
`ifdef CLINT_MMIO_SUBWORD_EN
    size_bad_s = 1'b0;
`else
    size_bad_s = (i_req_size != 2'd3);
`endif

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          addr_d    = i_req_addr;
          wdata_d   = i_req_wdata;
          req_wen_d = i_req_wen;
`ifdef CLINT_MMIO_SUBWORD_EN
          size_d    = i_req_size;
          uns_d     = i_req_unsigned;
`endif
          err_d     = !hit_s || misalign_s || size_bad_s;
          if (err_d) begin
            state_d = S_RESP;
          end else if (i_req_wen && (i_req_size == 2'd3)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        rbuf_d  = i_Clint_rdata;
        state_d = req_wen_q ? S_WR : S_RESP;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d  = (state_d == S_IDLE);
    cren_d   = (state_d == S_RD);
    cwen_d   = (state_d == S_WR);
    rvalid_d = (state_d == S_RESP);
    rerr_d   = (state_d == S_RESP) && err_d;

    if ((state_d == S_RD) || (state_d == S_WR)) begin
      caddr_d = {addr_d[63:3], 3'b000};
    end else begin
      caddr_d = 64'd0;
    end

    if (state_d == S_WR) begin
`ifdef CLINT_MMIO_SUBWORD_EN
      cwdata_d = store_merge(rbuf_d, wdata_d, size_d, addr_d[2:0]);
`else
      cwdata_d = wdata_d;
`endif
    end else begin
      cwdata_d = 64'd0;
    end

    if ((state_d == S_RESP) && !err_d && !req_wen_d) begin
`ifdef CLINT_MMIO_SUBWORD_EN
      rdata_d = load_extend(rbuf_d, size_d, addr_d[2:0], uns_d);
`else
      rdata_d = rbuf_d;
`endif
    end else begin
      rdata_d = 64'd0;
    end
  end

  // State, request context and registered outputs; synchronous reset drops any request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      rbuf_q    <= 64'd0;
      req_wen_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef CLINT_MMIO_SUBWORD_EN
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
`endif
      ready_q   <= 1'b1;
      cren_q    <= 1'b0;
      cwen_q    <= 1'b0;
      caddr_q   <= 64'd0;
      cwdata_q  <= 64'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 64'd0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      req_wen_q <= req_wen_d;
      err_q     <= err_d;
`ifdef CLINT_MMIO_SUBWORD_EN
      size_q    <= size_d;
      uns_q     <= uns_d;
`endif
      ready_q   <= ready_d;
      cren_q    <= cren_d;
      cwen_q    <= cwen_d;
      caddr_q   <= caddr_d;
      cwdata_q  <= cwdata_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
    end
  end

  // Outputs are held at zero for as long as rst_n is low.
  assign o_req_ready   = ready_q  & rst_n;
  assign o_Clint_ren   = cren_q   & rst_n;
  assign o_Clint_wen   = cwen_q   & rst_n;
  assign o_Clint_addr  = caddr_q  & {64{rst_n}};
  assign o_Clint_wdata = cwdata_q & {64{rst_n}};
  assign o_resp_valid  = rvalid_q & rst_n;
  assign o_resp_rdata  = rdata_q  & {64{rst_n}};
  assign o_resp_err    = rerr_q   & rst_n;

endmodule

// File: tb/tb_clint_mmio_master.sv
// Directed bench for clint_mmio_master with a small CLINT register model and
// an expectation queue filled when each request is driven.
module tb_clint_mmio_master;

  localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
`ifdef CLINT_MMIO_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] c_addr;
  logic [63:0] c_wdata;
  logic        c_wen;
  logic        c_ren;
  logic [63:0] c_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  clint_mmio_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_wen      (req_wen),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_Clint_addr   (c_addr),
    .o_Clint_wdata  (c_wdata),
    .o_Clint_wen    (c_wen),
    .o_Clint_ren    (c_ren),
    .i_Clint_rdata  (c_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CLINT model: free-running mtime, mtimecmp kept across core reset.
  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  assign c_rdata = !c_ren ? 64'd0 :
                   (c_addr == A_MTIME) ? mtime_r :
                   (c_addr == A_CMP)   ? mtimecmp_r : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clk) begin
    if (!rst_n) mtime_r <= 64'h0000_0000_0000_0100;
    else if (c_wen && (c_addr == A_MTIME)) mtime_r <= c_wdata;
    else mtime_r <= mtime_r + 64'd1;
    if (c_wen && (c_addr == A_CMP)) mtimecmp_r <= c_wdata;
  end

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    logic [7:0]  ren_mask;
    logic [7:0]  wen_mask;
    logic [63:0] wdata;
    logic [63:0] caddr;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] cmp_shadow;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] r, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
    int nb;
    logic [63:0] v;
    logic sgn;
    nb = 1 << int'(size);
    v  = 64'd0;
    for (int i = 0; i < 8; i++)
      if ((i < nb) && (int'(off) + i < 8)) v[8*i +: 8] = r[8*(int'(off)+i) +: 8];
    if ((nb < 8) && !uns) begin
      sgn = v[8*nb-1];
      for (int j = 0; j < 64; j++) if (j >= 8*nb) v[j] = sgn;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] r, input logic [63:0] w,
                                            input logic [2:0] off, input logic [1:0] size);
    int nb;
    logic [63:0] v;
    nb = 1 << int'(size);
    v  = r;
    for (int i = 0; i < 8; i++)
      if ((i < nb) && (int'(off) + i < 8)) v[8*(int'(off)+i) +: 8] = w[8*i +: 8];
    return v;
  endfunction

  // Drive one request, predict its outcome, then watch strobes until the response.
  task automatic run(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [1:0] size, input logic uns, input string tag);
    exp_t        e;
    exp_t        got_e;
    logic [63:0] regv;
    logic [63:0] rd, cw, ca, ra;
    logic [7:0]  rm, wm;
    logic        er, got, hit, mis;
    int          lat;
    @(negedge clk);
    hit = (addr[63:3] == A_MTIME[63:3]) || (addr[63:3] == A_CMP[63:3]);
    mis = (int'(addr[2:0]) % (1 << int'(size))) != 0;
    regv = (addr[63:3] == A_CMP[63:3]) ? cmp_shadow : mtime_r + 64'd1;
    e.err = !hit || mis || (!SUB && (size != 2'd3));
    e.rdata = 64'd0; e.ren_mask = 8'd0; e.wen_mask = 8'd0; e.wdata = 64'd0;
    e.caddr = {addr[63:3], 3'b000};
    if (e.err) begin
      e.lat = 1;
    end else if (!wen) begin
      e.lat = 2; e.ren_mask = 8'b0000_0010;
      e.rdata = ref_load(regv, addr[2:0], size, uns);
    end else if (size == 2'd3) begin
      e.lat = 2; e.wen_mask = 8'b0000_0010; e.wdata = wdata;
    end else begin
      e.lat = 3; e.ren_mask = 8'b0000_0010; e.wen_mask = 8'b0000_0100;
      e.wdata = ref_store(regv, wdata, addr[2:0], size);
    end
    if (!e.err && wen && (addr[63:3] == A_CMP[63:3])) cmp_shadow = e.wdata;
    sb_q.push_back(e);

    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_uns = uns;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    req_size = 2'd0; req_uns = 1'b0;

    got = 1'b0; lat = 0; rm = 8'd0; wm = 8'd0; rd = 64'd0; er = 1'b0;
    cw = 64'd0; ca = 64'd0; ra = 64'd0;
    for (int c = 1; (c <= 7) && !got; c++) begin
      @(negedge clk);
      if (c_ren) begin rm[3'(c)] = 1'b1; ra = c_addr; end
      if (c_wen) begin wm[3'(c)] = 1'b1; cw = c_wdata; ca = c_addr; end
      if (resp_valid) begin got = 1'b1; lat = c; rd = resp_rdata; er = resp_err; end
    end

    got_e = sb_q.pop_front();
    check({tag, "_latency"},  64'(lat),   64'(got_e.lat));
    check({tag, "_err"},      64'(er),    64'(got_e.err));
    check({tag, "_rdata"},    rd,         got_e.rdata);
    check({tag, "_ren_cyc"},  64'(rm),    64'(got_e.ren_mask));
    check({tag, "_wen_cyc"},  64'(wm),    64'(got_e.wen_mask));
    if (got_e.ren_mask != 8'd0) check({tag, "_raddr"}, ra, got_e.caddr);
    if (got_e.wen_mask != 8'd0) begin
      check({tag, "_waddr"}, ca, got_e.caddr);
      check({tag, "_wdata"}, cw, got_e.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_wen, seen_resp;
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; req_size = 2'd0; req_uns = 1'b0; cmp_shadow = 64'd0;

    repeat (2) @(negedge clk);
    check("rst_ready",  64'(req_ready),  64'd0);
    check("rst_rvalid", 64'(resp_valid), 64'd0);
    check("rst_ren",    64'(c_ren),      64'd0);
    check("rst_wen",    64'(c_wen),      64'd0);
    check("rst_caddr",  c_addr,          64'd0);
    check("rst_cwdata", c_wdata,         64'd0);
    check("rst_rdata",  resp_rdata,      64'd0);
    check("rst_err",    64'(resp_err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(req_ready), 64'd1);

    run(1'b0, A_MTIME,          64'd0,                    2'd3, 1'b0, "ld_mtime");
    run(1'b1, A_CMP,            64'h1122_3344_5566_7788,  2'd3, 1'b0, "sd_cmp");
    run(1'b0, A_CMP,            64'd0,                    2'd3, 1'b0, "ld_cmp");
    run(1'b1, A_CMP + 64'd3,    64'h0000_0000_0000_00AB,  2'd0, 1'b0, "sb_cmp3");
    run(1'b0, A_CMP,            64'd0,                    2'd3, 1'b0, "ld_after_sb");
    run(1'b1, A_CMP,            64'hFFFF_FFFF_0000_0000,  2'd3, 1'b0, "sd_cmp2");
    run(1'b0, A_CMP + 64'd4,    64'd0,                    2'd2, 1'b0, "lw");
    run(1'b0, A_CMP + 64'd4,    64'd0,                    2'd2, 1'b1, "lwu");
    run(1'b0, A_CMP,            64'd0,                    2'd1, 1'b0, "lh");
    run(1'b0, A_CMP + 64'd7,    64'd0,                    2'd0, 1'b1, "lbu7");
    run(1'b1, A_CMP + 64'd2,    64'h0000_0000_0000_BEEF,  2'd1, 1'b0, "sh2");
    run(1'b0, A_CMP,            64'd0,                    2'd3, 1'b0, "ld_after_sh");
    run(1'b0, A_CMP + 64'd1,    64'd0,                    2'd1, 1'b0, "lh_mis");
    run(1'b1, 64'h0000_0000_0200_0000, 64'd1,             2'd3, 1'b0, "sd_unmapped");
    run(1'b0, A_CMP + 64'd4,    64'd0,                    2'd3, 1'b0, "ld_mis");
    run(1'b1, A_CMP,            64'h0000_0000_1234_5678,  2'd2, 1'b0, "sw_cmp");
    run(1'b0, A_MTIME,          64'd0,                    2'd3, 1'b0, "ld_mtime2");

    // Reset during the RD cycle: the request must vanish without a write or response.
    @(negedge clk);
    check("midrst_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = SUB; req_addr = SUB ? A_CMP + 64'd2 : A_CMP;
    req_wdata = 64'h0000_0000_0000_005A; req_size = SUB ? 2'd0 : 2'd3; req_uns = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_size = 2'd0;
    @(negedge clk);
    check("midrst_rd_ren", 64'(c_ren), 64'd1);
    rst_n = 1'b0;
    seen_wen = 1'b0; seen_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen_wen  = seen_wen  | c_wen;
      seen_resp = seen_resp | resp_valid;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rel_ready", 64'(req_ready), 64'd1);
    repeat (4) begin
      seen_wen  = seen_wen  | c_wen;
      seen_resp = seen_resp | resp_valid;
      @(negedge clk);
    end
    check("midrst_no_wen",  64'(seen_wen),  64'd0);
    check("midrst_no_resp", 64'(seen_resp), 64'd0);
    run(1'b0, A_CMP, 64'd0, 2'd3, 1'b0, "ld_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
